// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory: datapath width and RV32I load/store
// funct3 encodings, plus a helper that classifies an access by size.
package data_memory_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SizeByte,
    SizeHalf,
    SizeWord,
    SizeNone
  } acc_size_e;

  // Access width implied by funct3, independent of load/store direction.
  function automatic acc_size_e f3_size(input logic [2:0] f3);
    acc_size_e s;
    case (f3)
      F3_B, F3_BU: s = SizeByte;
      F3_H, F3_HU: s = SizeHalf;
      F3_W:        s = SizeWord;
      default:     s = SizeNone;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: picks the addressed byte/halfword out of a stored word and
// sign- or zero-extends it according to funct3. Purely combinational.
module dmem_load_align
  import data_memory_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      lane_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection; halfwords ignore lane bit 0 (forced alignment).
  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Extension by access type; unknown funct3 yields zero.
  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{(XLEN - 8){byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {{(XLEN - 8){1'b0}}, byte_sel};
      F3_H:    data_o = {{(XLEN - 16){half_sel[15]}}, half_sel};
      F3_HU:   data_o = {{(XLEN - 16){1'b0}}, half_sel};
      F3_W:    data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Word-organised RV32I data memory: combinational loads, byte-enabled stores
// on the rising clock edge, asynchronous active-high reset clearing all words.
// Optional feature macro DMEM_MISALIGN_TRAP_EN: adds a sticky MisalignErr flag,
// suppresses misaligned stores and zeroes misaligned loads.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] Addr,
  input  logic [XLEN-1:0] WriteData,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic            MisalignErr,
`endif
  output logic [XLEN-1:0] ReadData
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic [3:0]        byte_en;
  logic [XLEN-1:0]   wr_lanes;
  logic [XLEN-1:0]   load_data;
  logic              block_access;

  // Address bits above the word index are ignored so addresses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Addr[XLEN-1:ADDR_W+2];

  assign word_idx = Addr[ADDR_W+1:2];
  assign lane     = Addr[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
  acc_size_e acc_size;
  logic      misaligned;
  logic      misalign_q, misalign_d;

  assign acc_size     = f3_size(Funct3);
  assign misaligned   = ((acc_size == SizeHalf) && Addr[0]) ||
                        ((acc_size == SizeWord) && (Addr[1:0] != 2'b00));
  assign block_access = misaligned;
  assign MisalignErr  = misalign_q;

  // Sticky flag: any misaligned read or write attempt latches it until reset.
  always_comb begin
    misalign_d = misalign_q | (misaligned & (MemRead | MemWrite));
  end

  // Error flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  assign block_access = 1'b0;
`endif

  // Byte enables and lane-replicated store data; low address bits beyond the
  // access size are ignored, giving forced alignment.
  always_comb begin
    byte_en  = 4'b0000;
    wr_lanes = WriteData;
    case (Funct3)
      F3_B: begin
        byte_en  = 4'b0001 << lane;
        wr_lanes = {4{WriteData[7:0]}};
      end
      F3_H: begin
        byte_en  = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{WriteData[15:0]}};
      end
      F3_W: begin
        byte_en  = 4'b1111;
        wr_lanes = WriteData;
      end
      default: begin
        byte_en  = 4'b0000;
        wr_lanes = WriteData;
      end
    endcase
    if (!MemWrite || block_access) begin
      byte_en = 4'b0000;
    end
  end

  // Next-state storage: merge enabled bytes into the addressed word.
  always_comb begin
    mem_d = mem_q;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) begin
        mem_d[word_idx][8*b +: 8] = wr_lanes[8*b +: 8];
      end
    end
  end

  // Storage array with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  dmem_load_align u_load_align (
    .word_i   (mem_q[word_idx]),
    .lane_i   (lane),
    .funct3_i (Funct3),
    .data_o   (load_data)
  );

  // Loads read pre-edge contents; gated to zero when not reading.
  always_comb begin
    ReadData = '0;
    if (MemRead && !block_access) begin
      ReadData = load_data;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed cases plus random traffic
// compared against a byte-addressed little-endian reference memory.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        MisalignErr;
`endif

  int total = 0;
  int bad   = 0;

  localparam int NBYTES = 1024;
  logic [7:0]  mref [NBYTES];
  logic        exp_mis;
  logic [31:0] last_rd;

  data_memory dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Funct3    (Funct3),
    .Addr      (Addr),
    .WriteData (WriteData),
`ifdef DMEM_MISALIGN_TRAP_EN
    .MisalignErr (MisalignErr),
`endif
    .ReadData  (ReadData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic is_mis(input logic [2:0] f3, input logic [31:0] a);
    return ((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
  endfunction

  // Effective byte address after wrap and forced alignment.
  function automatic int eff_addr(input logic [2:0] f3, input logic [31:0] a);
    int ba;
    ba = int'(a % NBYTES);
    if (f3 == 3'b001 || f3 == 3'b101) ba = ba - (ba % 2);
    if (f3 == 3'b010) ba = ba - (ba % 4);
    return ba;
  endfunction

  function automatic logic [31:0] ref_load(input logic rd, input logic [2:0] f3,
                                           input logic [31:0] a);
    int ba;
    logic [31:0] v;
    if (!rd) return 32'h0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (is_mis(f3, a)) return 32'h0;
`endif
    ba = eff_addr(f3, a);
    case (f3)
      3'b000: v = {{24{mref[ba][7]}}, mref[ba]};
      3'b100: v = {24'h0, mref[ba]};
      3'b001: v = {{16{mref[ba+1][7]}}, mref[ba+1], mref[ba]};
      3'b101: v = {16'h0, mref[ba+1], mref[ba]};
      3'b010: v = {mref[ba+3], mref[ba+2], mref[ba+1], mref[ba]};
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d);
    int ba;
    int n;
    if (!wr) return;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (is_mis(f3, a)) return;
`endif
    ba = eff_addr(f3, a);
    case (f3)
      3'b000:  n = 1;
      3'b001:  n = 2;
      3'b010:  n = 4;
      default: n = 0;
    endcase
    for (int i = 0; i < n; i++) mref[ba + i] = d[8*i +: 8];
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WriteData = d;
    #1;
    last_rd = ReadData;
    check("load", ReadData, ref_load(rd, f3, a));
    @(posedge clk);
    ref_store(wr, f3, a, d);
    if ((rd || wr) && is_mis(f3, a)) exp_mis = 1'b1;
    #1;
`ifdef DMEM_MISALIGN_TRAP_EN
    check("misalign_flag", {31'h0, MisalignErr}, {31'h0, exp_mis});
`endif
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
    access(1'b1, 1'b0, f3, a, 32'h0);
    check(tag, last_rd, exp);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    reset = 1'b1;
    #2;
    foreach (mref[i]) mref[i] = 8'h0;
    exp_mis = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] f3_tab [8];
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    foreach (mref[i]) mref[i] = 8'h0;
    exp_mis = 1'b0;
    reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010;
    Addr = 32'h0; WriteData = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_read", ReadData, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("reset_flag", {31'h0, MisalignErr}, 32'h0);
`endif
    reset = 1'b0;

    // Stores then mid-run reset
    access(1'b0, 1'b1, 3'b010, 32'h0, 32'hCAFEF00D);
    access(1'b0, 1'b1, 3'b010, 32'h3FC, 32'h12345678);
    pulse_reset();
    load_chk("rst_lw0", 3'b010, 32'h0, 32'h0);
    load_chk("rst_lw3fc", 3'b010, 32'h3FC, 32'h0);
    access(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    check("noread_zero", last_rd, 32'h0);

    // SW then loads of every width
    access(1'b0, 1'b1, 3'b010, 32'h10, 32'h800080F0);
    load_chk("lw10", 3'b010, 32'h10, 32'h800080F0);
    load_chk("lb10", 3'b000, 32'h10, 32'hFFFFFFF0);
    load_chk("lbu10", 3'b100, 32'h10, 32'h000000F0);
    load_chk("lh12", 3'b001, 32'h12, 32'hFFFF8000);
    load_chk("lhu12", 3'b101, 32'h12, 32'h00008000);
    load_chk("bad_f3", 3'b011, 32'h10, 32'h0);

    // Partial stores
    access(1'b0, 1'b1, 3'b010, 32'h20, 32'h0);
    access(1'b0, 1'b1, 3'b000, 32'h21, 32'hFFFFFFAB);
    load_chk("sb21", 3'b010, 32'h20, 32'h0000AB00);
    access(1'b0, 1'b1, 3'b001, 32'h22, 32'hFFFF1234);
    load_chk("sh22", 3'b010, 32'h20, 32'h1234AB00);

    // Address wrap
    access(1'b0, 1'b1, 3'b010, 32'h400, 32'h5A5A5A5A);
    load_chk("wrap", 3'b010, 32'h0, 32'h5A5A5A5A);

    // Same-cycle read and write
    access(1'b0, 1'b1, 3'b010, 32'h30, 32'h11);
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b1; Funct3 = 3'b010; Addr = 32'h30; WriteData = 32'h22;
    #1;
    check("rw_pre", ReadData, 32'h11);
    @(posedge clk);
    ref_store(1'b1, 3'b010, 32'h30, 32'h22);
    #1;
    check("rw_post", ReadData, 32'h22);

    // Misaligned store
    access(1'b0, 1'b1, 3'b010, 32'h40, 32'h01020304);
    access(1'b0, 1'b1, 3'b010, 32'h42, 32'hDEADBEEF);
`ifdef DMEM_MISALIGN_TRAP_EN
    load_chk("mis_sw", 3'b010, 32'h40, 32'h01020304);
    check("mis_flag_set", {31'h0, MisalignErr}, 32'h1);
    access(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    check("mis_flag_hold", {31'h0, MisalignErr}, 32'h1);
    pulse_reset();
    #1;
    check("mis_flag_clr", {31'h0, MisalignErr}, 32'h0);
`else
    load_chk("mis_sw", 3'b010, 32'h40, 32'hDEADBEEF);
`endif

    // Random traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             f3_tab[$urandom_range(0, 7)], 32'($urandom_range(0, 2047)), $urandom);
    end

    // Final reset sweep
    pulse_reset();
    load_chk("end_lw0", 3'b010, 32'h0, 32'h0);
    load_chk("end_lw3fc", 3'b010, 32'h3FC, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data memory directly downstream of the ALU in the single-cycle RISC-V datapath.
- Consumes the ALU result as the byte address for loads and stores.
- Supports RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
- Reads are combinational so load data reaches writeback in the same cycle; stores commit on the rising clock edge.

Parameters:
- DEPTH, 256, number of 32-bit words (power of 2).
- ADDR_W, 8, word-index width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; stores commit on the rising edge.
- reset  input  1  asynchronous, active-high; clears all storage.
- MemRead  input  1  load enable.
- MemWrite  input  1  store enable.
- Funct3  input  3  access size and sign, per the RV32I funct3 encoding.
- Addr  input  32  byte address taken from ALU_Out.
- WriteData  input  32  store data from register rs2; the low bytes are used for SB/SH.
- ReadData  output  32  load result, already extended to 32 bits.
- MisalignErr  output  1  sticky error flag; present only when DMEM_MISALIGN_TRAP_EN is defined.

Behaviour:
- Reset is asynchronous and active-high.
  - While reset=1, all DEPTH words are 0 and no store occurs.
  - ReadData follows the combinational rule below, so it reads 0 after reset.
- Word index is Addr[ADDR_W+1:2].
  - Address bits above that range are ignored, so addresses wrap modulo DEPTH*4.
  - Byte lane is Addr[1:0].
- Loads (combinational, 0-cycle latency):
  - ReadData = 0 whenever MemRead=0.
  - 000 LB: selected byte, sign-extended.
  - 100 LBU: selected byte, zero-extended.
  - 001 LH: halfword at lane Addr[1]*2, sign-extended.
  - 101 LHU: halfword at lane Addr[1]*2, zero-extended.
  - 010 LW: full word.
  - Any other Funct3: ReadData = 0.
- Stores (take effect at the rising clk edge when MemWrite=1 and reset=0):
  - 000 SB: WriteData[7:0] written into byte lane Addr[1:0].
  - 001 SH: WriteData[15:0] written into lanes Addr[1]*2 and Addr[1]*2+1.
  - 010 SW: all 4 lanes written.
  - Other Funct3: no write.
  - Bytes not enabled keep their value.
- Simultaneous events:
  - MemRead=1 and MemWrite=1 to the same word: ReadData shows the pre-edge contents; the write lands at the edge, and the new value is visible after the edge.
  - Reset asserted on a store edge: the store is discarded and contents are 0.
- Misalignment is defined as a halfword access with Addr[0]=1, or a word access with Addr[1:0]≠0. Without the optional feature:
  - Addr[0] is ignored for halfwords.
  - Addr[1:0] are ignored for words.
  - Misalignment is silent.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds the MisalignErr output, a register cleared by reset.
  - MisalignErr is set at the clk edge of any misaligned access with MemRead=1 or MemWrite=1, and stays set until reset.
  - A misaligned store is suppressed, so memory is unchanged.
  - A misaligned load returns 0.
- Undefined: no MisalignErr port and no extra flop; the forced-alignment behaviour above applies.

Decomposition:
- Shared package holds:
  - Funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - The XLEN=32 constant shared with the ALU.
- One sub-module, dmem_load_align: purely combinational; takes the word, Addr[1:0] and Funct3 and produces the extended ReadData.
- Byte-enable generation and storage stay in data_memory.

Test Plan:
- Reset, then read:
  - Assert reset mid-run after stores, then LW at Addr=0x0 and Addr=0x3FC → ReadData=0x00000000.
  - MemRead=0 → ReadData=0.
- SW then loads (SW 0x8000_80F0 at Addr=0x10):
  - LW 0x10 → 0x800080F0.
  - LB 0x10 → 0xFFFFFFF0; LBU 0x10 → 0x000000F0.
  - LH 0x12 → 0xFFFF8000; LHU 0x12 → 0x00008000.
- Partial stores:
  - SW 0 at 0x20, then SB WriteData=0xAB at 0x21 → LW 0x20 = 0x0000AB00.
  - Then SH 0x1234 at 0x22 → LW 0x20 = 0x1234AB00.
- Wrap and same-cycle read/write:
  - SW 0x5A5A5A5A at Addr=0x400 → LW 0x0 = 0x5A5A5A5A.
  - MemRead and MemWrite both high at 0x30 with old value 0x11, new value 0x22 → ReadData=0x11 before the edge, 0x22 after.
- Misaligned, with DMEM_MISALIGN_TRAP_EN:
  - SW at 0x42 → memory unchanged; MisalignErr=1 after the edge and held until reset.
- Misaligned, without the macro:
  - SW at 0x42 writes word 0x40.
